// File: rtl/serial_frame_receiver.sv
// Start/stop-bit framed serial receiver with a one-byte valid/ready holding register.
// Define SERIAL_FRAME_RX_PARITY_EN to check an even-parity bit between the data and stop bits.
module serial_frame_receiver #(
    parameter int DATA_BITS = 8,
    parameter int COUNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic [COUNT_W-1:0]   frame_count,
    output logic                 busy
);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY    = 3'd2,
`endif
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_cnt;
    logic                 last_bit;
    logic                 good_stop;
    logic                 bad_frame;

    assign last_bit = (bit_cnt == IDX_W'(DATA_BITS-1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        good_stop = 1'b0;
        bad_frame = 1'b0;
        case (state)
            IDLE:      if (!serial_in) state_nxt = DATA;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            DATA:      if (last_bit) state_nxt = PARITY;
            // Even parity: data bits plus parity bit must XOR to zero.
            PARITY: begin
                if (^{shift, serial_in}) begin
                    bad_frame = 1'b1;
                    state_nxt = WAIT_HIGH;
                end else begin
                    state_nxt = STOP;
                end
            end
`else
            DATA:      if (last_bit) state_nxt = STOP;
`endif
            STOP: begin
                if (serial_in) begin
                    good_stop = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    bad_frame = 1'b1;
                    state_nxt = WAIT_HIGH;
                end
            end
            // A held-low line must not look like a stream of new start bits.
            WAIT_HIGH: if (serial_in) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift       <= '0;
            bit_cnt     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_error <= bad_frame;
            overrun     <= good_stop & out_valid & ~out_ready;

            if (state == DATA) begin
                shift[bit_cnt] <= serial_in;
                bit_cnt        <= last_bit ? '0 : bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end

            // A completing frame may load in the same cycle the old byte is consumed.
            if (good_stop && (!out_valid || out_ready)) begin
                out_data    <= shift;
                out_valid   <= 1'b1;
                frame_count <= frame_count + COUNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
